// File: rtl/cdr_sequencer_pkg.sv
// Shared definitions for the BLE receiver clock-recovery sequencer and the recovery datapath.
// The recovery instance imports CDR_PIPELINE_STAGES from here so its latency and the ARM mask stay equal.
package cdr_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FLUSH  = 3'd1,
      ST_SEARCH = 3'd2,
      ST_ARM    = 3'd3,
      ST_TRACK  = 3'd4,
      ST_DONE   = 3'd5
   } cdr_state_t;

   localparam int CDR_SAMPLE_RATE      = 16;
   localparam int CDR_PIPELINE_STAGES  = 9;
   localparam int CDR_FLUSH_CYCLES     = 4;
   localparam int CDR_WATCHDOG_SYMBOLS = 2;
   localparam int CDR_CNT_W            = 12;
   localparam int CDR_MAX_SYMBOLS      = 2120;
   localparam int WD_LIMIT             = CDR_WATCHDOG_SYMBOLS * CDR_SAMPLE_RATE;

   function automatic int count_width(input int max_value);
      return (max_value < 2) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/cdr_watchdog.sv
// Loadable down-counter of qualified samples; expire flags the sample that takes it from 1 to 0.
// Shared between the post-preamble pipeline mask and the symbol-timing watchdog.
module cdr_watchdog #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         enable,
   output logic         expire
);

   logic [W-1:0] count;

   // A load wins over a decrement so a fresh symbol restarts the window even in the expiry cycle.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expire = enable && (count == W'(1));

endmodule

// File: rtl/cdr_sequencer.sv
// Run-time controller for the BLE clock recovery datapath: gating, soft clear, preamble
// qualification, pipeline masking, symbol counting and loss-of-timing re-arm.
module cdr_sequencer
   import cdr_sequencer_pkg::*;
#(
   parameter int SAMPLE_RATE      = CDR_SAMPLE_RATE,
   parameter int PIPELINE_STAGES  = CDR_PIPELINE_STAGES,
   parameter int FLUSH_CYCLES     = CDR_FLUSH_CYCLES,
   parameter int WATCHDOG_SYMBOLS = CDR_WATCHDOG_SYMBOLS,
   parameter int CNT_W            = CDR_CNT_W,
   parameter int MAX_SYMBOLS      = CDR_MAX_SYMBOLS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             sample_valid,
   input  logic             preamble_detected,
   input  logic             cr_symbol_clk,
   input  logic             pkt_len_valid,
   input  logic [CNT_W-1:0] pkt_len_symbols,
   output logic             cr_en,
   output logic             cr_clr,
   output logic             cr_preamble,
   output logic             sym_strobe,
   output logic [CNT_W-1:0] sym_count,
   output logic [2:0]       state_o,
   output logic             busy,
   output logic             done,
   output logic             lost
);

   localparam int WD_SAMPLES = WATCHDOG_SYMBOLS * SAMPLE_RATE;
   localparam int WD_W       = count_width((WD_SAMPLES > PIPELINE_STAGES) ? WD_SAMPLES : PIPELINE_STAGES);
   localparam int FLUSH_W    = count_width(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] LIMIT_MAX = CNT_W'(MAX_SYMBOLS);

   cdr_state_t       state_q;
   cdr_state_t       nxt;
   logic [FLUSH_W-1:0] flush_cnt;
   logic             run_q;
   logic [CNT_W-1:0] limit_q;
   logic             len_latched;
   logic [CNT_W-1:0] sym_count_inc;
   logic             sym_accept;
   logic             sym_lost;

   logic             wd_clear;
   logic             wd_load;
   logic [WD_W-1:0]  wd_load_value;
   logic             wd_enable;
   logic             wd_expire;

   assign wd_clear      = (state_q == ST_FLUSH);
   assign wd_enable     = sample_valid && ((state_q == ST_ARM) || (state_q == ST_TRACK));
   assign sym_count_inc = (sym_count == {CNT_W{1'b1}}) ? sym_count : sym_count + 1'b1;

   cdr_watchdog #(.W(WD_W)) u_watchdog (
      .clk        (clk),
      .reset      (reset),
      .clear      (wd_clear),
      .load       (wd_load),
      .load_value (wd_load_value),
      .enable     (wd_enable),
      .expire     (wd_expire)
   );

   // Transition rules; in TRACK a pending over-limit check beats a symbol, which beats expiry.
   always_comb begin
      nxt           = state_q;
      wd_load       = 1'b0;
      wd_load_value = WD_W'(WD_SAMPLES);
      sym_accept    = 1'b0;
      sym_lost      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (flush_cnt == '0) nxt = ST_SEARCH;
         end
         ST_SEARCH: begin
            if (sample_valid && preamble_detected) begin
               nxt           = ST_ARM;
               wd_load       = 1'b1;
               wd_load_value = WD_W'(PIPELINE_STAGES);
            end
         end
         ST_ARM: begin
            if (wd_expire) begin
               nxt     = ST_TRACK;
               wd_load = 1'b1;
            end
         end
         ST_TRACK: begin
            if (limit_q <= sym_count) begin
               nxt = ST_DONE;
            end else if (sample_valid && cr_symbol_clk) begin
               sym_accept = 1'b1;
               wd_load    = 1'b1;
               if (sym_count_inc == limit_q) nxt = ST_DONE;
            end else if (wd_expire) begin
               sym_lost = 1'b1;
               nxt      = ST_FLUSH;
            end
         end
         ST_DONE: begin
            nxt = ST_IDLE;
         end
         default: begin
            nxt = ST_IDLE;
         end
      endcase
      if (abort && (state_q != ST_IDLE)) begin
         nxt        = ST_IDLE;
         sym_accept = 1'b0;
         sym_lost   = 1'b0;
      end
   end

   // Every output except cr_en and cr_preamble is registered from the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         flush_cnt   <= FLUSH_W'(FLUSH_CYCLES - 1);
         run_q       <= 1'b0;
         cr_clr      <= 1'b1;
         busy        <= 1'b0;
         sym_strobe  <= 1'b0;
         sym_count   <= '0;
         done        <= 1'b0;
         lost        <= 1'b0;
         limit_q     <= LIMIT_MAX;
         len_latched <= 1'b0;
      end else begin
         state_q    <= nxt;
         run_q      <= (nxt == ST_SEARCH) || (nxt == ST_ARM) || (nxt == ST_TRACK);
         cr_clr     <= (nxt == ST_IDLE) || (nxt == ST_FLUSH);
         busy       <= (nxt != ST_IDLE);
         sym_strobe <= sym_accept;
         lost       <= sym_lost;
         done       <= (state_q == ST_DONE) && !abort;
         flush_cnt  <= (state_q == ST_FLUSH) ? flush_cnt - 1'b1 : FLUSH_W'(FLUSH_CYCLES - 1);
         if (nxt == ST_FLUSH) begin
            sym_count   <= '0;
            limit_q     <= LIMIT_MAX;
            len_latched <= 1'b0;
         end else begin
            if (sym_accept) sym_count <= sym_count_inc;
            if ((state_q == ST_TRACK) && pkt_len_valid && !len_latched && !abort) begin
               len_latched <= 1'b1;
               limit_q     <= (pkt_len_symbols == '0) ? LIMIT_MAX : pkt_len_symbols;
            end
         end
      end
   end

   assign cr_en       = sample_valid && run_q;
   assign cr_preamble = preamble_detected && sample_valid && (state_q == ST_SEARCH);
   assign state_o     = state_q;

endmodule

// File: tb/tb_cdr_sequencer.sv
// Randomized bench for cdr_sequencer against a sample-counting reference model of the sequencer rules.
module tb_cdr_sequencer;

   localparam int MAXS     = 2120;
   localparam int QUIET    = 32;
   localparam int MASK     = 9;
   localparam int FLUSHN   = 4;
   localparam int CNT_MAX  = 4095;

   logic        clk = 1'b0;
   logic        reset, start, abort, sample_valid, preamble_detected, cr_symbol_clk, pkt_len_valid;
   logic [11:0] pkt_len_symbols;
   logic        cr_en, cr_clr, cr_preamble, sym_strobe, busy, done, lost;
   logic [11:0] sym_count;
   logic [2:0]  state_o;

   always #5 clk = ~clk;

   cdr_sequencer dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .abort             (abort),
      .sample_valid      (sample_valid),
      .preamble_detected (preamble_detected),
      .cr_symbol_clk     (cr_symbol_clk),
      .pkt_len_valid     (pkt_len_valid),
      .pkt_len_symbols   (pkt_len_symbols),
      .cr_en             (cr_en),
      .cr_clr            (cr_clr),
      .cr_preamble       (cr_preamble),
      .sym_strobe        (sym_strobe),
      .sym_count         (sym_count),
      .state_o           (state_o),
      .busy              (busy),
      .done              (done),
      .lost              (lost)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: phase numbers follow the published state encodings.
   int m_phase = 0, m_flush = 0, m_mask = 0, m_quiet = 0, m_count = 0, m_limit = MAXS;
   bit m_have_len = 0, m_strobe = 0, m_done = 0, m_lost = 0;

   int p_sv = 80, p_pre = 20, gap_target = 4, gap_max = 20;
   bit stop_syms = 0, hit_expiry = 0, len_en = 0;
   int len_at = 0, len_val = 0, len_val2 = 0;
   int lost_seen = 0, done_seen = 0;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic enterFlush();
      m_phase = 1;
      m_flush = 0;
      m_count = 0;
      m_limit = MAXS;
      m_have_len = 0;
   endtask

   task automatic modelStep();
      bit sv;
      bit to_flush;
      sv = sample_valid;
      to_flush = 0;
      m_strobe = 0;
      m_done = 0;
      m_lost = 0;
      if (reset) begin
         m_phase = 0;
         m_count = 0;
         m_limit = MAXS;
         m_have_len = 0;
         return;
      end
      if (abort) begin
         m_phase = 0;
         return;
      end
      case (m_phase)
         0: if (start) enterFlush();
         1: begin
            m_flush++;
            if (m_flush == FLUSHN) m_phase = 2;
         end
         2: if (sv && preamble_detected) begin
            m_phase = 3;
            m_mask = 0;
         end
         3: if (sv) begin
            m_mask++;
            if (m_mask == MASK) begin
               m_phase = 4;
               m_quiet = 0;
            end
         end
         4: begin
            if (m_limit <= m_count) begin
               m_phase = 5;
            end else if (sv && cr_symbol_clk) begin
               m_strobe = 1;
               m_quiet = 0;
               if (m_count < CNT_MAX) m_count++;
               if (m_count == m_limit) m_phase = 5;
            end else if (sv) begin
               m_quiet++;
               if (m_quiet == QUIET) begin
                  m_lost = 1;
                  to_flush = 1;
               end
            end
            if (pkt_len_valid && !m_have_len) begin
               m_have_len = 1;
               m_limit = (pkt_len_symbols == 0) ? MAXS : int'(pkt_len_symbols);
            end
            if (to_flush) enterFlush();
         end
         5: begin
            m_done = 1;
            m_phase = 0;
         end
         default: m_phase = 0;
      endcase
   endtask

   // One clock: drive inputs, check combinational outputs, clock the model, check registered outputs.
   task automatic applyStimulus(input bit st, input bit ab, input bit rst);
      bit sv;
      sv = ($urandom_range(99) < p_sv);
      reset = rst;
      start = st;
      abort = ab;
      sample_valid = sv;
      preamble_detected = (m_phase == 2) ? ($urandom_range(99) < p_pre) : ($urandom_range(99) < 10);
      if (m_phase == 4) begin
         if (stop_syms)
            cr_symbol_clk = hit_expiry ? (sv && (m_quiet == QUIET - 1)) : (!sv && ($urandom_range(99) < 20));
         else
            cr_symbol_clk = sv ? (m_quiet + 1 >= gap_target) : ($urandom_range(99) < 20);
      end else begin
         cr_symbol_clk = ($urandom_range(99) < 30);
      end
      if (m_phase == 4) begin
         pkt_len_valid = len_en && (m_count >= len_at);
         pkt_len_symbols = m_have_len ? 12'(len_val2) : 12'(len_val);
      end else begin
         pkt_len_valid = ($urandom_range(99) < 5);
         pkt_len_symbols = 12'($urandom);
      end
      #1;
      if (!rst) begin
         checkOutput("cr_en", cr_en, int'(sv && m_phase >= 2 && m_phase <= 4));
         checkOutput("cr_preamble", cr_preamble, int'(sv && preamble_detected && m_phase == 2));
      end
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("state_o", state_o, m_phase);
      checkOutput("cr_clr", cr_clr, int'(m_phase <= 1));
      checkOutput("busy", busy, int'(m_phase != 0));
      checkOutput("sym_strobe", sym_strobe, m_strobe);
      checkOutput("sym_count", sym_count, m_count);
      checkOutput("done", done, m_done);
      checkOutput("lost", lost, m_lost);
      if (lost) lost_seen++;
      if (done) done_seen++;
      if (m_strobe) gap_target = $urandom_range(gap_max, 1);
   endtask

   task automatic waitPhase(input string tag, input int phase, input int budget);
      int n = 0;
      while (int'(state_o) != phase && n < budget) begin
         applyStimulus(0, 0, 0);
         n++;
      end
      checkOutput(tag, state_o, phase);
   endtask

   initial begin
      int flush_len;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      sample_valid = 1'b0;
      preamble_detected = 1'b0;
      cr_symbol_clk = 1'b0;
      pkt_len_valid = 1'b0;
      pkt_len_symbols = '0;

      applyStimulus(0, 0, 1);
      applyStimulus(0, 0, 1);
      checkOutput("reset_cr_clr", cr_clr, 1);
      checkOutput("reset_busy", busy, 0);

      // Start and flush length
      p_sv = 100;
      applyStimulus(1, 0, 0);
      flush_len = 0;
      while (state_o == 3'd1 && flush_len < 10) begin
         applyStimulus(0, 0, 0);
         flush_len++;
      end
      checkOutput("flush_cycles", flush_len, FLUSHN);
      checkOutput("search_after_flush", state_o, 2);

      // Packet of 40 symbols, length arriving after symbol 10, second length ignored
      p_sv = 80;
      len_en = 1; len_at = 10; len_val = 40; len_val2 = 100;
      waitPhase("pkt40_done_state", 5, 4000);
      applyStimulus(0, 0, 0);
      checkOutput("pkt40_done_pulse", done, 1);
      checkOutput("pkt40_idle", state_o, 0);
      checkOutput("pkt40_count", sym_count, 40);

      // Symbol in the expiry sample keeps lock; then silence loses it
      len_en = 0;
      applyStimulus(1, 0, 0);
      waitPhase("to_track_a", 4, 600);
      repeat (40) applyStimulus(0, 0, 0);
      p_sv = 100;
      stop_syms = 1; hit_expiry = 1;
      lost_seen = 0;
      repeat (70) applyStimulus(0, 0, 0);
      checkOutput("expiry_symbol_no_lost", lost_seen, 0);
      checkOutput("expiry_symbol_track", state_o, 4);
      hit_expiry = 0;
      waitPhase("lost_to_flush", 1, 100);
      checkOutput("lost_pulse", lost, 1);
      checkOutput("lost_count_cleared", sym_count, 0);
      stop_syms = 0;

      // start ignored in TRACK, abort from TRACK
      p_sv = 75;
      waitPhase("relock_track", 4, 600);
      applyStimulus(1, 0, 0);
      checkOutput("start_ignored", state_o, 4);
      done_seen = 0; lost_seen = 0;
      applyStimulus(0, 1, 0);
      checkOutput("abort_track_idle", state_o, 0);
      applyStimulus(0, 0, 0);
      checkOutput("abort_track_no_pulse", done_seen + lost_seen, 0);

      // abort from ARM
      applyStimulus(1, 0, 0);
      waitPhase("to_arm", 3, 600);
      applyStimulus(0, 1, 0);
      checkOutput("abort_arm_idle", state_o, 0);
      checkOutput("abort_arm_cr_clr", cr_clr, 1);

      // Default limit, with no length and with a zero length
      p_sv = 100; gap_max = 3;
      for (int pass = 0; pass < 2; pass++) begin
         len_en = (pass == 1); len_at = 5; len_val = 0; len_val2 = 0;
         applyStimulus(1, 0, 0);
         waitPhase("max_done_state", 5, 12000);
         applyStimulus(0, 0, 0);
         checkOutput("max_done_pulse", done, 1);
         checkOutput("max_count", sym_count, MAXS);
      end

      // Length latched below the current count
      p_sv = 85; gap_max = 8;
      len_en = 1; len_at = 8; len_val = 5; len_val2 = 5;
      applyStimulus(1, 0, 0);
      waitPhase("late_limit_done", 5, 2000);
      applyStimulus(0, 0, 0);
      checkOutput("late_limit_pulse", done, 1);

      // Reset mid-packet
      len_en = 0; gap_max = 20;
      applyStimulus(1, 0, 0);
      waitPhase("to_track_b", 4, 600);
      repeat (30) applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 1);
      checkOutput("midreset_state", state_o, 0);
      checkOutput("midreset_count", sym_count, 0);

      // Random soak
      p_sv = 60; len_en = 1;
      for (int i = 0; i < 1500; i++) begin
         if (m_phase == 0 && (i % 50) == 0) begin
            len_at = $urandom_range(30);
            len_val = $urandom_range(60);
            len_val2 = $urandom_range(60);
         end
         applyStimulus($urandom_range(99) < 5, $urandom_range(199) < 1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
